queue_param_status: RTL and testbench
=====================================

QUEUE_PARAM_STATUS -- requirements
Module: queue_param_status

Interface
REQ-001 Parameter num_of_words, 32, FIFO depth in words; SHALL equal 2**pointer_width.
REQ-002 Parameter word_length, 8, bits per word.
REQ-003 Parameter pointer_width, 5, read/write pointer width.
REQ-004 Parameter fwft_mode, 0; 0 = standard registered read, 1 = first-word-fall-through.
REQ-005 clk  input  1  single clock; all state changes on rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 data_in  input  word_length  write data.
REQ-008 write_to_stack  input  1  write request.
REQ-009 read_from_stack  input  1  read request.
REQ-010 almost_full_level  input  pointer_width+1  almost-full threshold.
REQ-011 almost_empty_level  input  pointer_width+1  almost-empty threshold.
REQ-012 clear_errors  input  1  synchronous clear of sticky error flags.
REQ-013 data_out  output  word_length  read data.
REQ-014 data_valid  output  1  data_out qualifier.
REQ-015 stack_full  output  1  count == num_of_words.
REQ-016 stack_empty  output  1  count == 0.
REQ-017 almost_full  output  1  count >= almost_full_level.
REQ-018 almost_empty  output  1  count <= almost_empty_level.
REQ-019 word_count  output  pointer_width+1  current occupancy, 0..num_of_words.
REQ-020 overflow  output  1  sticky: a write was dropped.
REQ-021 underflow  output  1  sticky: a read was rejected.

Function
REQ-022 Read accepted = read_from_stack && !stack_empty.
REQ-023 Write accepted = write_to_stack && (!stack_full || read accepted).
REQ-024 Accepted write stores data_in at write pointer; write pointer increments modulo num_of_words (wraps to 0 after num_of_words-1).
REQ-025 Accepted read advances read pointer modulo num_of_words.
REQ-026 word_count: +1 on write-only, -1 on read-only, unchanged when both or neither accepted; registered.
REQ-027 All status flags combinationally derived from registered word_count; update in cycle after the causing edge.
REQ-028 Full + read + write same cycle: both accepted, count stays num_of_words, no overflow.
REQ-029 Empty + read + write same cycle: write accepted, read rejected, underflow sets, count becomes 1.
REQ-030 fwft_mode=0: on accepted read, data_out registers head word at that edge; data_valid high exactly one cycle after each accepted read; data_out holds otherwise.
REQ-031 fwft_mode=1: data_out = word at read pointer whenever !stack_empty; data_valid = !stack_empty; first write visible on data_out one cycle after write edge; read pops and exposes next word next cycle.
REQ-032 overflow sets when write_to_stack and write not accepted; underflow sets when read_from_stack and stack_empty.
REQ-033 clear_errors clears overflow/underflow next edge; a set condition in the same cycle wins.
REQ-034 Threshold inputs sampled continuously; changes reflect in almost_full/almost_empty in same cycle.

Reset
REQ-035 Asserting reset immediately (no clock) forces pointers=0, word_count=0, data_out=0, data_valid=0, overflow=0, underflow=0; stack_empty=1, stack_full=0, almost_full per threshold, almost_empty=1.
REQ-036 Reset mid-operation discards all stored words; memory array contents need not be cleared.
REQ-037 Operation resumes on the first rising edge after reset deasserts.

Verification
REQ-038 Standard mode: write 1,10,20 then 3 reads -> data_out 1,10,20 with data_valid pulse each one cycle after read; stack_empty=1 after third read.
REQ-039 Fill 32 words then one extra write -> stack_full=1, word_count=32, overflow=1, extra word never read back; clear_errors -> overflow=0.
REQ-040 Read while empty -> underflow=1, word_count stays 0, data_out unchanged.
REQ-041 Full with simultaneous read+write of 42 -> count stays 32, no overflow; 42 emerges as 32nd subsequent read; pointers wrap correctly.
REQ-042 almost_full_level=4, almost_empty_level=1: write 4 words -> almost_full=1 at count 4, almost_empty=0 at count 2.
REQ-043 fwft_mode=1: write 35 -> data_out=35, data_valid=1 next cycle without read; reset asserted mid-stream -> stack_empty=1, data_valid=0 immediately.

Source files
------------

// File: rtl/queue_param_status.sv
`default_nettype none
// ============================================================================
// Module      : queue_param_status
// Description : Parameterised single-clock FIFO with standard or FWFT read
//               port, occupancy-derived status flags and sticky error flags.
// Revision    : 1.0
// ============================================================================
module queue_param_status #(
  parameter int num_of_words  = 32,
  parameter int word_length   = 8,
  parameter int pointer_width = 5,
  parameter bit fwft_mode     = 1'b0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [word_length-1:0]   data_in,
  input  logic                     write_to_stack,
  input  logic                     read_from_stack,
  input  logic [pointer_width:0]   almost_full_level,
  input  logic [pointer_width:0]   almost_empty_level,
  input  logic                     clear_errors,
  output logic [word_length-1:0]   data_out,
  output logic                     data_valid,
  output logic                     stack_full,
  output logic                     stack_empty,
  output logic                     almost_full,
  output logic                     almost_empty,
  output logic [pointer_width:0]   word_count,
  output logic                     overflow,
  output logic                     underflow
);

  localparam logic [pointer_width:0]   c_full_count = (pointer_width+1)'(num_of_words);
  localparam logic [pointer_width-1:0] c_last_ptr   = pointer_width'(num_of_words - 1);

  logic [word_length-1:0]   mem_q [num_of_words];
  logic [pointer_width-1:0] rd_ptr_q, rd_ptr_d;
  logic [pointer_width-1:0] wr_ptr_q, wr_ptr_d;
  logic [pointer_width:0]   count_q, count_d;
  logic                     overflow_q, overflow_d;
  logic                     underflow_q, underflow_d;
  logic                     w_rd_acc, w_wr_acc;

  assign word_count   = count_q;
  assign stack_full   = (count_q == c_full_count);
  assign stack_empty  = (count_q == '0);
  assign almost_full  = (count_q >= almost_full_level);
  assign almost_empty = (count_q <= almost_empty_level);
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

  always_comb begin
    w_rd_acc = read_from_stack && !stack_empty;
    // A pop in the same cycle frees a slot, so a full FIFO still accepts the write.
    w_wr_acc = write_to_stack && (!stack_full || w_rd_acc);

    rd_ptr_d = rd_ptr_q;
    if (w_rd_acc) begin
      rd_ptr_d = (rd_ptr_q == c_last_ptr) ? '0 : rd_ptr_q + 1'b1;
    end

    wr_ptr_d = wr_ptr_q;
    if (w_wr_acc) begin
      wr_ptr_d = (wr_ptr_q == c_last_ptr) ? '0 : wr_ptr_q + 1'b1;
    end

    count_d = count_q;
    case ({w_wr_acc, w_rd_acc})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    // Set conditions are applied after the clear so they take priority.
    overflow_d = overflow_q;
    if (clear_errors) overflow_d = 1'b0;
    if (write_to_stack && !w_wr_acc) overflow_d = 1'b1;

    underflow_d = underflow_q;
    if (clear_errors) underflow_d = 1'b0;
    if (read_from_stack && stack_empty) underflow_d = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr_acc) begin
      mem_q[wr_ptr_q] <= data_in;
    end
  end

  generate
    if (fwft_mode) begin : g_fwft
      assign data_out   = stack_empty ? '0 : mem_q[rd_ptr_q];
      assign data_valid = !stack_empty;
    end else begin : g_std
      logic [word_length-1:0] dout_q, dout_d;
      logic                   valid_q, valid_d;

      always_comb begin
        dout_d  = w_rd_acc ? mem_q[rd_ptr_q] : dout_q;
        valid_d = w_rd_acc;
      end

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          dout_q  <= '0;
          valid_q <= 1'b0;
        end else begin
          dout_q  <= dout_d;
          valid_q <= valid_d;
        end
      end

      assign data_out   = dout_q;
      assign data_valid = valid_q;
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_queue_param_status.sv
`default_nettype none
// ============================================================================
// Module      : tb_queue_param_status
// Description : Self-checking bench driving a standard and an FWFT instance
//               with shared stimulus against a queue-based reference model.
// Revision    : 1.0
// ============================================================================
module tb_queue_param_status;
  localparam int DEPTH = 32;

  logic       clk, reset, write_to_stack, read_from_stack, clear_errors;
  logic [7:0] data_in;
  logic [5:0] almost_full_level, almost_empty_level;

  logic [7:0] s_dout, f_dout;
  logic [5:0] s_cnt, f_cnt;
  logic s_dv, f_dv, s_full, f_full, s_empty, f_empty, s_af, f_af, s_ae, f_ae;
  logic s_ovf, f_ovf, s_unf, f_unf;

  int checks = 0;
  int failures = 0;

  logic [7:0] q[$];
  logic [7:0] m_dout;
  logic       m_dv, m_ovf, m_unf;

  queue_param_status #(.num_of_words(32), .word_length(8), .pointer_width(5), .fwft_mode(1'b0)) u_std (
    .clk(clk), .reset(reset), .data_in(data_in), .write_to_stack(write_to_stack),
    .read_from_stack(read_from_stack), .almost_full_level(almost_full_level),
    .almost_empty_level(almost_empty_level), .clear_errors(clear_errors),
    .data_out(s_dout), .data_valid(s_dv), .stack_full(s_full), .stack_empty(s_empty),
    .almost_full(s_af), .almost_empty(s_ae), .word_count(s_cnt),
    .overflow(s_ovf), .underflow(s_unf));

  queue_param_status #(.num_of_words(32), .word_length(8), .pointer_width(5), .fwft_mode(1'b1)) u_fwft (
    .clk(clk), .reset(reset), .data_in(data_in), .write_to_stack(write_to_stack),
    .read_from_stack(read_from_stack), .almost_full_level(almost_full_level),
    .almost_empty_level(almost_empty_level), .clear_errors(clear_errors),
    .data_out(f_dout), .data_valid(f_dv), .stack_full(f_full), .stack_empty(f_empty),
    .almost_full(f_af), .almost_empty(f_ae), .word_count(f_cnt),
    .overflow(f_ovf), .underflow(f_unf));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // One clock of stimulus; the model advances from the rules, then the edge is taken.
  task automatic drive(input logic wr, input logic rd, input logic [7:0] din, input logic clr);
    int n;
    bit rd_ok, wr_ok;
    n     = q.size();
    rd_ok = rd && (n > 0);
    wr_ok = wr && ((n < DEPTH) || rd_ok);
    if (clr) begin m_ovf = 1'b0; m_unf = 1'b0; end
    if (wr && !wr_ok) m_ovf = 1'b1;
    if (rd && (n == 0)) m_unf = 1'b1;
    m_dv = rd_ok;
    if (rd_ok) m_dout = q.pop_front();
    if (wr_ok) q.push_back(din);
    write_to_stack  = wr;
    read_from_stack = rd;
    data_in         = din;
    clear_errors    = clr;
    @(posedge clk);
    #1;
    write_to_stack  = 1'b0;
    read_from_stack = 1'b0;
    clear_errors    = 1'b0;
  endtask

  task automatic model_reset();
    q.delete();
    m_dout = 8'd0; m_dv = 1'b0; m_ovf = 1'b0; m_unf = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    write_to_stack = 1'b0; read_from_stack = 1'b0; clear_errors = 1'b0; data_in = 8'd0;
    almost_full_level = 6'd28; almost_empty_level = 6'd2;
    model_reset();
    @(posedge clk); #2;
    checks++; if (s_cnt !== 6'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", s_cnt); end
    checks++; if (s_empty !== 1'b1 || s_full !== 1'b0) begin failures++; $display("FAIL reset_empty_full got=%b%b exp=10", s_empty, s_full); end
    checks++; if (s_dout !== 8'd0 || s_dv !== 1'b0) begin failures++; $display("FAIL reset_dout got=%0d/%b exp=0/0", s_dout, s_dv); end
    checks++; if (s_ovf !== 1'b0 || s_unf !== 1'b0) begin failures++; $display("FAIL reset_errors got=%b%b exp=00", s_ovf, s_unf); end
    checks++; if (s_ae !== 1'b1 || s_af !== 1'b0) begin failures++; $display("FAIL reset_almost got=ae%b af%b exp=ae1 af0", s_ae, s_af); end
    checks++; if (f_dv !== 1'b0 || f_dout !== 8'd0) begin failures++; $display("FAIL reset_fwft got=%0d/%b exp=0/0", f_dout, f_dv); end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_std_sequence();
    logic [7:0] vals [3];
    vals[0] = 8'd1; vals[1] = 8'd10; vals[2] = 8'd20;
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, vals[i], 1'b0);
    checks++; if (s_cnt !== 6'd3) begin failures++; $display("FAIL seq_count got=%0d exp=3", s_cnt); end
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b1, 8'd0, 1'b0);
      checks++; if (s_dout !== vals[i] || s_dv !== 1'b1) begin failures++; $display("FAIL seq_read%0d got=%0d/%b exp=%0d/1", i, s_dout, s_dv, vals[i]); end
    end
    checks++; if (s_empty !== 1'b1) begin failures++; $display("FAIL seq_empty got=%b exp=1", s_empty); end
    drive(1'b0, 1'b0, 8'd0, 1'b0);
    checks++; if (s_dv !== 1'b0 || s_dout !== 8'd20) begin failures++; $display("FAIL seq_hold got=%0d/%b exp=20/0", s_dout, s_dv); end
  endtask

  task automatic test_fill_overflow();
    for (int i = 0; i < DEPTH; i++) drive(1'b1, 1'b0, 8'(100 + i), 1'b0);
    checks++; if (s_full !== 1'b1 || s_cnt !== 6'd32 || s_ovf !== 1'b0) begin failures++; $display("FAIL fill_full got=full%b cnt%0d ovf%b exp=1/32/0", s_full, s_cnt, s_ovf); end
    drive(1'b1, 1'b0, 8'hEE, 1'b0);
    checks++; if (s_ovf !== 1'b1 || s_cnt !== 6'd32 || s_full !== 1'b1) begin failures++; $display("FAIL fill_overflow got=ovf%b cnt%0d exp=1/32", s_ovf, s_cnt); end
    drive(1'b0, 1'b0, 8'd0, 1'b1);
    checks++; if (s_ovf !== 1'b0) begin failures++; $display("FAIL fill_clear got=%b exp=0", s_ovf); end
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b0, 1'b1, 8'd0, 1'b0);
      checks++; if (s_dout !== 8'(100 + i)) begin failures++; $display("FAIL fill_drain%0d got=%0d exp=%0d", i, s_dout, 100 + i); end
    end
    checks++; if (s_empty !== 1'b1) begin failures++; $display("FAIL fill_drained got=%b exp=1", s_empty); end
  endtask

  task automatic test_underflow();
    drive(1'b0, 1'b1, 8'd0, 1'b0);
    checks++; if (s_unf !== 1'b1 || f_unf !== 1'b1) begin failures++; $display("FAIL unf_set got=%b/%b exp=1", s_unf, f_unf); end
    checks++; if (s_cnt !== 6'd0 || s_dout !== 8'd131 || s_dv !== 1'b0) begin failures++; $display("FAIL unf_state got=cnt%0d dout%0d dv%b exp=0/131/0", s_cnt, s_dout, s_dv); end
    // Empty with simultaneous read and write: write lands, read is rejected.
    drive(1'b1, 1'b1, 8'd77, 1'b1);
    checks++; if (s_cnt !== 6'd1 || s_unf !== 1'b1 || s_dv !== 1'b0) begin failures++; $display("FAIL unf_rw got=cnt%0d unf%b dv%b exp=1/1/0", s_cnt, s_unf, s_dv); end
    drive(1'b0, 1'b1, 8'd0, 1'b1);
    checks++; if (s_dout !== 8'd77 || s_unf !== 1'b0) begin failures++; $display("FAIL unf_clear got=dout%0d unf%b exp=77/0", s_dout, s_unf); end
  endtask

  task automatic test_full_rw();
    for (int i = 0; i < DEPTH; i++) drive(1'b1, 1'b0, 8'($urandom_range(0, 255)), 1'b0);
    drive(1'b1, 1'b1, 8'd42, 1'b0);
    checks++; if (s_cnt !== 6'd32 || s_ovf !== 1'b0 || s_dout !== m_dout || s_dv !== 1'b1) begin failures++; $display("FAIL fullrw_state got=cnt%0d ovf%b dout%0d exp=32/0/%0d", s_cnt, s_ovf, s_dout, m_dout); end
    for (int i = 1; i <= DEPTH; i++) begin
      drive(1'b0, 1'b1, 8'd0, 1'b0);
      checks++; if (s_dout !== m_dout || f_cnt !== 6'(q.size())) begin failures++; $display("FAIL fullrw_read%0d got=%0d/%0d exp=%0d/%0d", i, s_dout, f_cnt, m_dout, q.size()); end
    end
    checks++; if (s_dout !== 8'd42 || s_empty !== 1'b1) begin failures++; $display("FAIL fullrw_last got=%0d empty%b exp=42/1", s_dout, s_empty); end
  endtask

  task automatic test_thresholds();
    almost_full_level = 6'd4; almost_empty_level = 6'd1;
    drive(1'b1, 1'b0, 8'd5, 1'b0);
    checks++; if (s_ae !== 1'b1 || s_af !== 1'b0) begin failures++; $display("FAIL thr_c1 got=ae%b af%b exp=1/0", s_ae, s_af); end
    drive(1'b1, 1'b0, 8'd6, 1'b0);
    checks++; if (s_ae !== 1'b0 || s_af !== 1'b0) begin failures++; $display("FAIL thr_c2 got=ae%b af%b exp=0/0", s_ae, s_af); end
    drive(1'b1, 1'b0, 8'd7, 1'b0);
    checks++; if (s_af !== 1'b0) begin failures++; $display("FAIL thr_c3 got=af%b exp=0", s_af); end
    drive(1'b1, 1'b0, 8'd8, 1'b0);
    checks++; if (s_af !== 1'b1 || s_cnt !== 6'd4) begin failures++; $display("FAIL thr_c4 got=af%b cnt%0d exp=1/4", s_af, s_cnt); end
    almost_full_level = 6'd6; almost_empty_level = 6'd5;
    #1;
    checks++; if (s_af !== 1'b0 || s_ae !== 1'b1) begin failures++; $display("FAIL thr_live got=af%b ae%b exp=0/1", s_af, s_ae); end
    for (int i = 0; i < 4; i++) drive(1'b0, 1'b1, 8'd0, 1'b0);
    almost_full_level = 6'd28; almost_empty_level = 6'd2;
  endtask

  task automatic test_random();
    int wr_pct, rd_pct;
    wr_pct = 50; rd_pct = 50;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      if (cyc % 100 == 0) begin wr_pct = $urandom_range(10, 90); rd_pct = 100 - wr_pct; end
      almost_full_level  = 6'($urandom_range(0, 33));
      almost_empty_level = 6'($urandom_range(0, 33));
      drive($urandom_range(0, 99) < wr_pct, $urandom_range(0, 99) < rd_pct,
            8'($urandom_range(0, 255)), $urandom_range(0, 15) == 0);
      checks++; if (s_cnt !== 6'(q.size()) || f_cnt !== 6'(q.size())) begin failures++; $display("FAIL rnd_count cyc%0d got=%0d/%0d exp=%0d", cyc, s_cnt, f_cnt, q.size()); end
      checks++; if (s_dv !== m_dv || (m_dv && s_dout !== m_dout) || s_dout !== m_dout) begin failures++; $display("FAIL rnd_std_data cyc%0d got=%0d/%b exp=%0d/%b", cyc, s_dout, s_dv, m_dout, m_dv); end
      checks++; if (f_dv !== (q.size() > 0) || (q.size() > 0 && f_dout !== q[0])) begin failures++; $display("FAIL rnd_fwft_data cyc%0d got=%0d/%b exp=%0d/%b", cyc, f_dout, f_dv, (q.size() > 0) ? q[0] : 8'd0, q.size() > 0); end
      checks++; if (s_full !== (q.size() == DEPTH) || s_empty !== (q.size() == 0)) begin failures++; $display("FAIL rnd_full_empty cyc%0d got=%b%b exp=%b%b", cyc, s_full, s_empty, q.size() == DEPTH, q.size() == 0); end
      checks++; if (s_af !== (q.size() >= int'(almost_full_level)) || s_ae !== (q.size() <= int'(almost_empty_level))) begin failures++; $display("FAIL rnd_almost cyc%0d got=af%b ae%b cnt%0d afl%0d ael%0d", cyc, s_af, s_ae, q.size(), almost_full_level, almost_empty_level); end
      checks++; if (s_ovf !== m_ovf || s_unf !== m_unf || f_ovf !== m_ovf || f_unf !== m_unf) begin failures++; $display("FAIL rnd_errors cyc%0d got=%b%b exp=%b%b", cyc, s_ovf, s_unf, m_ovf, m_unf); end
    end
  endtask

  task automatic test_fwft_reset();
    #2 reset = 1'b1;
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    almost_full_level = 6'd28; almost_empty_level = 6'd2;
    drive(1'b1, 1'b0, 8'd35, 1'b0);
    checks++; if (f_dout !== 8'd35 || f_dv !== 1'b1) begin failures++; $display("FAIL fwft_first got=%0d/%b exp=35/1", f_dout, f_dv); end
    drive(1'b1, 1'b0, 8'd36, 1'b0);
    drive(1'b1, 1'b0, 8'd37, 1'b0);
    drive(1'b0, 1'b1, 8'd0, 1'b0);
    checks++; if (f_dout !== 8'd36 || f_dv !== 1'b1 || s_dout !== 8'd35) begin failures++; $display("FAIL fwft_pop got=%0d/%0d exp=36/35", f_dout, s_dout); end
    #2 reset = 1'b1;
    model_reset();
    #1;
    checks++; if (f_empty !== 1'b1 || f_dv !== 1'b0 || f_cnt !== 6'd0 || f_dout !== 8'd0) begin failures++; $display("FAIL fwft_async_reset got=empty%b dv%b cnt%0d exp=1/0/0", f_empty, f_dv, f_cnt); end
    checks++; if (s_empty !== 1'b1 || s_dout !== 8'd0 || s_dv !== 1'b0) begin failures++; $display("FAIL std_async_reset got=empty%b dout%0d exp=1/0", s_empty, s_dout); end
    @(negedge clk);
    reset = 1'b0;
    drive(1'b1, 1'b0, 8'd99, 1'b0);
    checks++; if (f_dout !== 8'd99 || f_cnt !== 6'd1) begin failures++; $display("FAIL fwft_resume got=%0d cnt%0d exp=99/1", f_dout, f_cnt); end
  endtask

  initial begin
    test_reset();
    test_std_sequence();
    test_fill_overflow();
    test_underflow();
    test_full_rw();
    test_thresholds();
    test_random();
    test_fwft_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
